// File: rtl/ifetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_OUTST_DEF = 2;
  localparam int FREE_W_DEF    = 4;

  // Written in place of the bus data when a fetch returns an error.
  localparam logic [31:0] INST_NOP = 32'h00000013;

  typedef enum logic {
    IFS_IDLE = 1'b0,
    IFS_REQ  = 1'b1
  } ifs_state_e;

endpackage

// File: rtl/ifetch_seq_if.sv
// Instruction bus: pipelined read requests with in-order responses.
interface ifetch_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, output addr, input gnt, input rvalid, input rdata, input err);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata, output err);
endinterface

// File: rtl/ifetch_cnt.sv
// Saturating up/down counter with synchronous clear; used for live and drop counts.
module ifetch_cnt #(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_i,
  input  logic [3:0] add_i,
  input  logic       dec_i,
  output logic [2:0] cnt_o
);

  logic [2:0] cnt_q, cnt_d;
  logic [4:0] sum;

  // Add, then decrement, then clamp into 0..MAX; clear wins over everything.
  always_comb begin
    sum = {2'b00, cnt_q} + {1'b0, add_i};
    if (dec_i && (sum != 5'd0)) sum = sum - 5'd1;
    if (sum > 5'(MAX)) sum = 5'(MAX);
    cnt_d = clr_i ? 3'd0 : sum[2:0];
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= 3'd0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ifetch_seq.sv
// Pops fetch addresses, issues pipelined bus reads, writes in-order responses
// into the instruction FIFO and discards stale responses after a flush.
module ifetch_seq
  import ifetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int FREE_W    = FREE_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              af_empty_i,
  input  logic [ADDR_W-1:0] af_rdata_i,
  output logic              af_ren_o,
  input  logic [FREE_W-1:0] if_free_i,
  output logic              if_wen_o,
  output logic [DATA_W-1:0] if_wdata_o,
  ifetch_seq_if.master      ibus,
  output logic              busy_o,
  output logic              err_o
);

  ifs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [2:0] live, drop;
  logic       req_pend, gnt_acc, kept, drop_rv, issue;
  logic [3:0] outst;
  logic [4:0] free_use;
  logic [3:0] drop_add;

  assign req_pend = (state_q == IFS_REQ);
  assign gnt_acc  = ibus.gnt & req_pend;
  assign kept     = ibus.rvalid & (drop == 3'd0);
  assign drop_rv  = ibus.rvalid & (drop != 3'd0);

  // A response arriving this cycle frees its slot immediately, which is what
  // lets a zero-wait slave sustain one fetch per cycle.
  assign outst    = 4'(req_pend) + 4'(live) - 4'(kept) + 4'(drop) - 4'(drop_rv);
  assign free_use = 5'(req_pend) + 5'(live) + 5'(wen_q);

  // rstn gates the pop so the address FIFO is never touched while in reset.
  assign issue = rstn & ~af_empty_i & ~flush_i
               & (32'(outst) < 32'(MAX_OUTST))
               & (32'(free_use) < 32'(if_free_i))
               & (~req_pend | ibus.gnt);

  assign drop_add = flush_i ? ({1'b0, live} + 4'(gnt_acc)) : 4'd0;

  ifetch_cnt #(.MAX(MAX_OUTST)) u_live (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (flush_i),
    .add_i (4'(gnt_acc)),
    .dec_i (kept),
    .cnt_o (live)
  );

  // During a flush every response is stale, whether it was owed to drop or live.
  ifetch_cnt #(.MAX(MAX_OUTST)) u_drop (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (1'b0),
    .add_i (drop_add),
    .dec_i (flush_i ? ibus.rvalid : drop_rv),
    .cnt_o (drop)
  );

  // Next-state, captured address and response register logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wen_d   = kept & ~flush_i;
    if (kept) begin
      wdata_d = ibus.err ? DATA_W'(INST_NOP) : ibus.rdata;
      if (ibus.err) err_d = 1'b1;
    end
    if (issue) addr_d = af_rdata_i;
    case (state_q)
      IFS_IDLE: if (issue) state_d = IFS_REQ;
      IFS_REQ:  if (ibus.gnt) state_d = issue ? IFS_REQ : IFS_IDLE;
      default:  state_d = IFS_IDLE;
    endcase
    if (flush_i) state_d = IFS_IDLE;
  end

  // Request FSM and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IFS_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ibus.req   = req_pend & ~flush_i;
  assign ibus.addr  = addr_q;
  assign af_ren_o   = issue;
  assign if_wen_o   = wen_q & ~flush_i;
  assign if_wdata_o = wdata_q;
  assign busy_o     = req_pend | (live != 3'd0) | (drop != 3'd0);
  assign err_o      = err_q;

endmodule
